// File: rtl/result_display_ctrl_if.sv
// Bundle of capture, selection and display signals for result_display_ctrl.
// master drives capture/selection inputs; slave (the controller) drives the display outputs.
interface result_display_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LED_W  = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned PAGES = DATA_W / LED_W;
    localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned HW    = $clog2(DEPTH);

    logic [DATA_W-1:0] result_in;
    logic              result_valid;
    logic              freeze;
    logic [PW-1:0]     page_sel;
    logic [HW-1:0]     hist_sel;
    logic              auto_scroll;
    logic [LED_W-1:0]  led;
    logic [HW:0]       hist_count;
    logic [7:0]        drop_count;

    modport master (
        output result_in, result_valid, freeze, page_sel, hist_sel, auto_scroll,
        input  led, hist_count, drop_count
    );

    modport slave (
        input  result_in, result_valid, freeze, page_sel, hist_sel, auto_scroll,
        output led, hist_count, drop_count
    );
endinterface

// File: rtl/result_display_ctrl.sv
// Captures processor results into a small history buffer and shows one LED_W slice on the LEDs.
// Optional page auto-scroll is built when RESULT_DISPLAY_AUTO_SCROLL_EN is defined.
module result_display_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SCROLL_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    result_display_ctrl_if.slave bus
);
    localparam int unsigned PAGES = DATA_W / LED_W;
    localparam int unsigned PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned HW    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [HW-1:0]     wp_q, wp_d;
    logic [HW:0]       hc_q, hc_d;
    logic [7:0]        dc_q, dc_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              capture_c;
    logic [HW-1:0]     rd_idx;
    logic [DATA_W-1:0] sel_entry;
    logic [PW-1:0]     page;

    assign capture_c = bus.result_valid & ~bus.freeze;

    // Write pointer, occupancy and drop counter next state
    always_comb begin
        wp_d = wp_q;
        hc_d = hc_q;
        dc_d = dc_q;
        if (capture_c) begin
            wp_d = wp_q + HW'(1);
            if (hc_q != (HW+1)'(DEPTH)) hc_d = hc_q + (HW+1)'(1);
        end
        if (bus.result_valid && bus.freeze && (dc_q != 8'hFF)) dc_d = dc_q + 8'd1;
    end

    // Entry selection uses the post-capture pointer so a new result shows one edge later
    always_comb begin
        rd_idx    = wp_q - HW'(1) - bus.hist_sel;
        sel_entry = '0;
        if ({1'b0, bus.hist_sel} < hc_q) sel_entry = mem[rd_idx];
        led_d = '0;
        for (int unsigned p = 0; p < PAGES; p++) begin
            if (page == PW'(p)) led_d = sel_entry[p*LED_W +: LED_W];
        end
    end

`ifdef RESULT_DISPLAY_AUTO_SCROLL_EN
    localparam int unsigned CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] spage_q, spage_d;

    always_comb begin
        cnt_d   = cnt_q;
        spage_d = spage_q;
        if (!bus.auto_scroll) begin
            cnt_d   = '0;
            spage_d = '0;
        end else if (cnt_q == CW'(SCROLL_DIV - 1)) begin
            cnt_d   = '0;
            spage_d = (spage_q == PW'(PAGES - 1)) ? '0 : spage_q + PW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            spage_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            spage_q <= spage_d;
        end
    end

    assign page = bus.auto_scroll ? spage_q : bus.page_sel;
`else
    logic        unused_auto_scroll;
    logic [31:0] unused_scroll_div;

    assign unused_auto_scroll = bus.auto_scroll;
    assign unused_scroll_div  = 32'(SCROLL_DIV);
    assign page               = bus.page_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            hc_q  <= '0;
            dc_q  <= '0;
            led_q <= '0;
        end else begin
            wp_q  <= wp_d;
            hc_q  <= hc_d;
            dc_q  <= dc_d;
            led_q <= led_d;
        end
    end

    // Entries are never reset; hist_count gates what can be read
    always_ff @(posedge clk) begin
        if (capture_c) mem[wp_q] <= bus.result_in;
    end

    assign bus.led        = led_q;
    assign bus.hist_count = hc_q;
    assign bus.drop_count = dc_q;
endmodule

// File: tb/tb_result_display_ctrl.sv
// Self-checking bench for result_display_ctrl (DATA_W=32, LED_W=16, DEPTH=4, SCROLL_DIV=4).
module tb_result_display_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    result_display_ctrl_if #(.DATA_W(32), .LED_W(16), .DEPTH(4)) bus ();

    result_display_ctrl #(
        .DATA_W(32), .LED_W(16), .DEPTH(4), .SCROLL_DIV(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        f;
        logic        as;
        logic [31:0] data;
        logic [1:0]  hs;
        logic        ps;
        logic [15:0] led;
        logic [2:0]  hc;
        logic [7:0]  dc;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb [$];
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic as,
                                input logic [31:0] data, input logic [1:0] hs, input logic ps,
                                input logic [15:0] led, input logic [2:0] hc, input logic [7:0] dc);
        vec_t r;
        r.v = v; r.f = f; r.as = as; r.data = data; r.hs = hs; r.ps = ps;
        r.led = led; r.hc = hc; r.dc = dc;
        return r;
    endfunction

    // One row per cycle: drive just after the falling edge, expectation queued for the monitor
    task automatic drive(input vec_t r);
        @(negedge clk);
        #1;
        bus.result_valid = r.v;
        bus.freeze       = r.f;
        bus.auto_scroll  = r.as;
        bus.result_in    = r.data;
        bus.hist_sel     = r.hs;
        bus.page_sel     = r.ps;
        sb.push_back(r);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: expectations for a row are due on the falling edge after its rising edge
    always @(negedge clk) begin : mon
        vec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("led",        32'(bus.led),        32'(e.led));
            check("hist_count", 32'(bus.hist_count), 32'(e.hc));
            check("drop_count", 32'(bus.drop_count), 32'(e.dc));
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] exp_led;
        logic        ps;

        rst_n            = 1'b0;
        bus.result_valid = 1'b0;
        bus.freeze       = 1'b0;
        bus.auto_scroll  = 1'b0;
        bus.result_in    = '0;
        bus.hist_sel     = '0;
        bus.page_sel     = '0;

        repeat (2) @(negedge clk);
        check("rst_led",  32'(bus.led),        32'd0);
        check("rst_hc",   32'(bus.hist_count), 32'd0);
        check("rst_dc",   32'(bus.drop_count), 32'd0);
        #2 rst_n = 1'b1;

        //           v  f  as data          hs ps led       hc dc
        tbl.push_back(mk(1, 0, 0, 32'hDEAD_BEEF, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 16'hBEEF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 1, 16'hDEAD, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h1,         0, 0, 16'hBEEF, 2, 0));
        tbl.push_back(mk(1, 0, 0, 32'h2,         0, 0, 16'h0001, 3, 0));
        tbl.push_back(mk(1, 0, 0, 32'h3,         0, 0, 16'h0002, 4, 0));
        tbl.push_back(mk(1, 0, 0, 32'h4,         0, 0, 16'h0003, 4, 0));
        tbl.push_back(mk(1, 0, 0, 32'h5,         0, 0, 16'h0004, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 16'h0005, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 16'h0004, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         2, 0, 16'h0003, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         3, 0, 16'h0002, 4, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         3, 1, 16'h0000, 4, 0));
        tbl.push_back(mk(1, 1, 0, 32'hAAAA_AAAA, 0, 0, 16'h0005, 4, 1));
        tbl.push_back(mk(1, 1, 0, 32'hAAAA_AAAA, 0, 0, 16'h0005, 4, 2));
        tbl.push_back(mk(1, 1, 0, 32'hAAAA_AAAA, 0, 0, 16'h0005, 4, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 16'h0005, 4, 3));
        tbl.push_back(mk(1, 0, 0, 32'h6,         0, 0, 16'h0005, 4, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 16'h0006, 4, 3));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 16'h0006, 4, 3));
        tbl.push_back(mk(1, 0, 0, 32'h7,         1, 0, 16'h0005, 4, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 0, 16'h0006, 4, 3));
        foreach (tbl[i]) drive(tbl[i]);
        drain();

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led),        32'd0);
        check("async_rst_hc",  32'(bus.hist_count), 32'd0);
        check("async_rst_dc",  32'(bus.drop_count), 32'd0);

        // A strobe during reset must be dropped
        @(negedge clk);
        bus.result_valid = 1'b1;
        bus.result_in    = 32'hBAD0_BAD0;
        bus.hist_sel     = '0;
        bus.page_sel     = '0;
        @(negedge clk);
        bus.result_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_hc",  32'(bus.hist_count), 32'd0);
        check("post_rst_led", 32'(bus.led),        32'd0);

        tbl.delete();
        tbl.push_back(mk(1, 0, 0, 32'h1111_2222, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h3333_4444, 0, 0, 16'h2222, 2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         3, 0, 16'h0000, 2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         2, 0, 16'h0000, 2, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 1, 16'h1111, 2, 0));
        tbl.push_back(mk(1, 0, 0, 32'h1234_5678, 0, 0, 16'h4444, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 0, 16'h5678, 3, 0));
        foreach (tbl[i]) drive(tbl[i]);

        // Auto-scroll window: page_sel toggles every 3 cycles to expose which source is used
        for (int i = 0; i < 12; i++) begin
            ps = 1'((i / 3) % 2);
`ifdef RESULT_DISPLAY_AUTO_SCROLL_EN
            exp_led = (((i / 4) % 2) != 0) ? 16'h1234 : 16'h5678;
`else
            exp_led = ps ? 16'h1234 : 16'h5678;
`endif
            drive(mk(0, 0, 1, 32'h0, 0, ps, exp_led, 3, 0));
        end
        drive(mk(0, 0, 0, 32'h0, 0, 1, 16'h1234, 3, 0));
        drive(mk(0, 0, 0, 32'h0, 0, 0, 16'h5678, 3, 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
